// File: rtl/host_spi_pkg.sv
// Shared types and constants for the oversampling host SPI bridge.
package host_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HDR  = 2'b01,
        ST_DATA = 2'b10,
        ST_NACK = 2'b11
    } state_e;

    // Header bit positions, counted down from the MSB: bit index = DW - HDR_x
    localparam int HDR_BUSY = 1;
    localparam int HDR_OVF  = 2;

    // Edge codes formed as {previous, current}
    localparam logic [1:0] RISE = 2'b01;
    localparam logic [1:0] FALL = 2'b10;

    function automatic logic [1:0] edge_code(input logic prev_v, input logic cur_v);
        return {prev_v, cur_v};
    endfunction

endpackage

// File: rtl/host_spi_bridge_if.sv
// Host/SPI bus bundle for host_spi_bridge; master = host/SPI side, slave = bridge.
interface host_spi_bridge_if #(
    parameter int DW    = 16,
    parameter int DEPTH = 512
);
    logic                     spi_sclk;
    logic                     spi_cs_n;
    logic                     spi_mosi;
    logic                     spi_miso;
    logic                     host_rdy;
    logic                     host_srq;
    logic                     tx_wr;
    logic [DW-1:0]            tx_din;
    logic                     tx_full;
    logic                     rx_rd;
    logic [DW-1:0]            rx_dout;
    logic                     rx_empty;
    logic [$clog2(DEPTH):0]   rx_level;
    logic                     ovf;

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, host_rdy, tx_wr, tx_din, rx_rd,
        input  spi_miso, host_srq, tx_full, rx_dout, rx_empty, rx_level, ovf
    );

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, host_rdy, tx_wr, tx_din, rx_rd,
        output spi_miso, host_srq, tx_full, rx_dout, rx_empty, rx_level, ovf
    );

endinterface

// File: rtl/SYNC_WIRE.sv
// Multi-flop synchroniser for a single asynchronous wire (NSYNC >= 2).
module SYNC_WIRE #(
    parameter int   NSYNC = 2,
    parameter logic INIT  = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [NSYNC-1:0] r_sync;

    // shift the raw input through the synchroniser chain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {NSYNC{INIT}};
        end else begin
            r_sync <= {r_sync[NSYNC-2:0], i_d};
        end
    end

    assign o_q = r_sync[NSYNC-1];

endmodule

// File: rtl/host_spi_fifo.sv
// Synchronous first-word-fall-through FIFO; an empty FIFO presents the last popped word.
module host_spi_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 512
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr,
    input  logic [DW-1:0]            i_din,
    input  logic                     i_rd,
    output logic [DW-1:0]            o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [DW-1:0] r_last;
    logic          w_do_wr;
    logic          w_do_rd;

    assign o_full  = (r_cnt == CNT_MAX);
    assign o_empty = (r_cnt == '0);
    assign o_level = r_cnt;
    assign w_do_rd = i_rd & ~o_empty;
    // a full FIFO still accepts a write when a read frees a slot in the same cycle
    assign w_do_wr = i_wr & (~o_full | w_do_rd);
    assign o_dout  = o_empty ? r_last : r_mem[r_rp];

    // storage array write port
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wp] <= i_din;
        end
    end

    // pointers, occupancy and held output word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_last <= '0;
        end else begin
            if (w_do_wr) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_do_rd) begin
                r_rp   <= r_rp + PTR_ONE;
                r_last <= r_mem[r_rp];
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/host_spi_bridge.sv
// Single-clock host SPI bridge: oversampled mode-0 slave with rx/tx word FIFOs.
// Optional status header enabled by defining HOST_SPI_STATUS_EN.
module host_spi_bridge
    import host_spi_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 512,
    parameter int NSYNC = 2
) (
    input  logic              hb_clk,
    input  logic              hb_rst,
    host_spi_bridge_if.slave  bus
);
    localparam int BW = $clog2(DW);
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
`ifdef HOST_SPI_STATUS_EN
    localparam logic [31:0] SAT_MAX = (32'd1 << (DW - 2)) - 32'd1;
`endif

    state_e          r_state;
    state_e          w_state_n;
    logic            w_sclk_s, w_cs_s, w_mosi_s;
    logic            r_sclk_d, r_cs_d;
    logic            w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic            w_start, w_hdr_done, w_word_done, w_word_start, w_end;
    logic            w_shift_st;
    logic            r_rdy, r_ack, r_ovf, r_srq, r_miso, r_rx_push;
    logic [BW-1:0]   r_bitcnt;
    logic [DW-1:0]   r_tx_sh, r_rx_sh;
    logic [DW-1:0]   w_hdr, w_tx_word, w_tx_dout;
    logic            w_tx_empty, w_tx_pop, w_rx_full;
    logic [$clog2(DEPTH):0] w_tx_level_unused;
`ifdef HOST_SPI_STATUS_EN
    logic [31:0]     w_lvl_sat;
`endif

    SYNC_WIRE #(.NSYNC(NSYNC), .INIT(1'b0)) u_sync_sclk (
        .i_clk(hb_clk), .i_rst(hb_rst), .i_d(bus.spi_sclk), .o_q(w_sclk_s));
    SYNC_WIRE #(.NSYNC(NSYNC), .INIT(1'b1)) u_sync_cs (
        .i_clk(hb_clk), .i_rst(hb_rst), .i_d(bus.spi_cs_n), .o_q(w_cs_s));
    SYNC_WIRE #(.NSYNC(NSYNC), .INIT(1'b0)) u_sync_mosi (
        .i_clk(hb_clk), .i_rst(hb_rst), .i_d(bus.spi_mosi), .o_q(w_mosi_s));

    assign w_sclk_rise = (edge_code(r_sclk_d, w_sclk_s) == RISE);
    assign w_sclk_fall = (edge_code(r_sclk_d, w_sclk_s) == FALL);
    assign w_cs_rise   = (edge_code(r_cs_d, w_cs_s) == RISE);
    assign w_cs_fall   = (edge_code(r_cs_d, w_cs_s) == FALL);
    assign w_shift_st  = (r_state == ST_HDR) || (r_state == ST_DATA);

    host_spi_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
        .i_clk(hb_clk), .i_rst(hb_rst),
        .i_wr(r_rx_push), .i_din(r_rx_sh), .i_rd(bus.rx_rd),
        .o_dout(bus.rx_dout), .o_full(w_rx_full), .o_empty(bus.rx_empty),
        .o_level(bus.rx_level));

    host_spi_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
        .i_clk(hb_clk), .i_rst(hb_rst),
        .i_wr(bus.tx_wr), .i_din(bus.tx_din), .i_rd(w_tx_pop),
        .o_dout(w_tx_dout), .o_full(bus.tx_full), .o_empty(w_tx_empty),
        .o_level(w_tx_level_unused));

    // an empty tx FIFO feeds zeros rather than stalling the shifter
    assign w_tx_pop  = w_word_start & ~w_tx_empty;
    assign w_tx_word = w_tx_empty ? '0 : w_tx_dout;

    // header word; the busy bit reflects the ack being latched this cycle
    always_comb begin
        w_hdr = '0;
        w_hdr[DW-HDR_BUSY] = ~r_rdy;
`ifdef HOST_SPI_STATUS_EN
        w_hdr[DW-HDR_OVF] = r_ovf;
        w_lvl_sat = (32'(bus.rx_level) > SAT_MAX) ? SAT_MAX : 32'(bus.rx_level);
        w_hdr[DW-3:0] = w_lvl_sat[DW-3:0];
`endif
    end

    // FSM state register
    always_ff @(posedge hb_clk or posedge hb_rst) begin
        if (hb_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // FSM next state and per-cycle event strobes
    always_comb begin
        w_state_n    = r_state;
        w_start      = 1'b0;
        w_hdr_done   = 1'b0;
        w_word_done  = 1'b0;
        w_word_start = 1'b0;
        w_end        = 1'b0;
        if (w_cs_rise) begin
            w_state_n = ST_IDLE;
            w_end     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_n = ST_HDR;
                        w_start   = 1'b1;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (w_sclk_rise && (r_bitcnt == BIT_LAST)) begin
                        w_hdr_done = 1'b1;
                        w_state_n  = r_ack ? ST_DATA : ST_NACK;
                    end else begin
                        w_state_n = ST_HDR;
                    end
                end
                ST_DATA: begin
                    if (w_sclk_rise && (r_bitcnt == BIT_LAST)) begin
                        w_word_done = 1'b1;
                    end else if (w_sclk_fall && (r_bitcnt == '0)) begin
                        w_word_start = 1'b1;
                    end else begin
                        w_state_n = ST_DATA;
                    end
                end
                ST_NACK: w_state_n = ST_NACK;
                default: w_state_n = ST_IDLE;
            endcase
        end
    end

    // edge history, handshake flags, shifters and status
    always_ff @(posedge hb_clk or posedge hb_rst) begin
        if (hb_rst) begin
            r_sclk_d  <= 1'b0;
            r_cs_d    <= 1'b1;
            r_rdy     <= 1'b0;
            r_ack     <= 1'b0;
            r_ovf     <= 1'b0;
            r_srq     <= 1'b0;
            r_miso    <= 1'b1;
            r_rx_push <= 1'b0;
            r_bitcnt  <= '0;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
        end else begin
            r_sclk_d  <= w_sclk_s;
            r_cs_d    <= w_cs_s;
            r_srq     <= w_end & r_ack;
            r_rx_push <= w_word_done;

            // a coincident srq wins over a new host_rdy
            if (r_srq) begin
                r_rdy <= 1'b0;
            end else if (bus.host_rdy) begin
                r_rdy <= 1'b1;
            end else begin
                r_rdy <= r_rdy;
            end

            if (w_start) begin
                r_ack <= r_rdy;
            end else if (w_end) begin
                r_ack <= 1'b0;
            end else begin
                r_ack <= r_ack;
            end

            if (w_start || w_end) begin
                r_bitcnt <= '0;
            end else if (w_sclk_rise && w_shift_st) begin
                r_bitcnt <= r_bitcnt + BIT_ONE;
                r_rx_sh  <= {r_rx_sh[DW-2:0], w_mosi_s};
            end else begin
                r_bitcnt <= r_bitcnt;
            end

            if (w_start) begin
                r_miso  <= w_hdr[DW-1];
                r_tx_sh <= {w_hdr[DW-2:0], 1'b0};
            end else if ((w_state_n == ST_IDLE) || (w_state_n == ST_NACK)) begin
                r_miso <= 1'b1;
            end else if (w_word_start) begin
                r_miso  <= w_tx_word[DW-1];
                r_tx_sh <= {w_tx_word[DW-2:0], 1'b0};
            end else if (w_sclk_fall && w_shift_st) begin
                r_miso  <= r_tx_sh[DW-1];
                r_tx_sh <= {r_tx_sh[DW-2:0], 1'b0};
            end else begin
                r_miso <= r_miso;
            end

            if (r_rx_push && w_rx_full && !bus.rx_rd) begin
                r_ovf <= 1'b1;
`ifdef HOST_SPI_STATUS_EN
            end else if (w_hdr_done && r_ack) begin
                r_ovf <= 1'b0;
`endif
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    assign bus.spi_miso = r_miso;
    assign bus.host_srq = r_srq;
    assign bus.ovf      = r_ovf;

endmodule
